// File: rtl/xoodyak_digest_collector.sv
// xoodyak_digest_collector: assembles squeezed hash bytes into a digest; optional compare via DIGEST_COMPARE_EN
module xoodyak_digest_collector #(
  parameter int DIGEST_BYTES = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [7:0]                hash_in,
  input  logic                      hash_valid,
  input  logic [7:0]                hash_idx,
  input  logic                      clear,
  output logic [8*DIGEST_BYTES-1:0] digest,
  output logic                      digest_valid,
  input  logic                      digest_ready,
  output logic                      busy,
  output logic                      overflow,
  output logic                      seq_err
`ifdef DIGEST_COMPARE_EN
  ,
  input  logic [8*DIGEST_BYTES-1:0] expected,
  output logic                      match
`endif
);
  localparam int CW = $clog2(DIGEST_BYTES) + 1;
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [8*DIGEST_BYTES-1:0] digest_q, digest_d;
  logic                      ovf_q, ovf_d, seq_q, seq_d;
  logic                      take, last, hs;
  assign take         = hash_valid && state_q != HOLD;
  assign last         = cnt_q == CW'(DIGEST_BYTES - 1);
  assign hs           = state_q == HOLD && digest_ready;
  assign digest       = digest_q;
  assign digest_valid = state_q == HOLD;
  assign busy         = state_q != IDLE;
  assign overflow     = ovf_q;
  assign seq_err      = seq_q;
  // next state: clear wins, otherwise accept a byte or complete the handshake
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    digest_d = digest_q;
    ovf_d    = ovf_q;
    seq_d    = seq_q;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      seq_d   = 1'b0;
    end else begin
      if (take) begin
        for (int k = 0; k < DIGEST_BYTES; k++)
          if (cnt_q == CW'(k)) digest_d[8*k +: 8] = hash_in;
        cnt_d   = cnt_q + CW'(1);
        seq_d   = seq_q | (hash_idx != 8'(cnt_q));
        state_d = last ? HOLD : COLLECT;
      end
      if (state_q == HOLD) begin
        ovf_d = ovf_q | hash_valid;
        if (digest_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    end
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      digest_q <= '0;
      ovf_q    <= 1'b0;
      seq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digest_q <= digest_d;
      ovf_q    <= ovf_d;
      seq_q    <= seq_d;
    end
  end
`ifdef DIGEST_COMPARE_EN
  logic match_q;
  assign match = match_q;
  // compare against the completed digest so match is valid together with digest_valid
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) match_q <= 1'b0;
    else if (clear || hs) match_q <= 1'b0;
    else if (take && last) match_q <= digest_d == expected;
  end
`endif
endmodule

// File: doc/xoodyak_digest_collector.md
XOODYAK_DIGEST_COLLECTOR -- requirements
Module: xoodyak_digest_collector

Interface
REQ-001 SHALL have parameter DIGEST_BYTES, default 32: number of hash bytes per digest; legal range 2..64.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port resetn, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port hash_in, input, 8 bits: hash byte from the Xoodyak squeeze stage.
REQ-005 SHALL have port hash_valid, input, 1 bit: hash_in is valid this cycle; one byte per high cycle.
REQ-006 SHALL have port hash_idx, input, 8 bits: producer's byte index for hash_in.
REQ-007 SHALL have port clear, input, 1 bit: synchronous abort back to IDLE.
REQ-008 SHALL have port digest, output, 8*DIGEST_BYTES bits: assembled digest; byte k is at bits [8k+7:8k].
REQ-009 SHALL have port digest_valid, output, 1 bit: digest is complete and stable.
REQ-010 SHALL have port digest_ready, input, 1 bit: consumer accepts the digest.
REQ-011 SHALL have port busy, output, 1 bit: a collection is in progress.
REQ-012 SHALL have port overflow, output, 1 bit: sticky; a byte arrived while HOLD.
REQ-013 SHALL have port seq_err, output, 1 bit: sticky; hash_idx did not equal the expected index.

Function
REQ-014 SHALL implement the FSM states IDLE, COLLECT and HOLD.
REQ-015 In IDLE, hash_valid SHALL capture byte 0 and move to COLLECT; when DIGEST_BYTES==1 it moves to HOLD instead.
REQ-016 In COLLECT, each hash_valid SHALL write hash_in to the byte slot given by the internal counter, then increment the counter.
- The counter is $clog2(DIGEST_BYTES)+1 bits wide.
- No wrap occurs inside a collection.
REQ-017 Capture of byte DIGEST_BYTES-1 SHALL move the FSM to HOLD and assert digest_valid in the next cycle, one cycle after the final byte.
REQ-018 In HOLD, digest and digest_valid SHALL stay stable until digest_valid && digest_ready is high.
- On that handshake: return to IDLE, clear the counter, and deassert digest_valid in the following cycle.
REQ-019 Any hash_valid in HOLD, including the handshake cycle, SHALL drop the byte and set overflow.
REQ-020 If hash_valid is high and hash_idx differs from the counter value, the byte SHALL still be stored at the counter slot and seq_err SHALL be set.
REQ-021 busy SHALL be 1 in COLLECT and in HOLD, and 0 in IDLE.
REQ-022 clear SHALL force IDLE, zero the counter and deassert digest_valid; it takes priority over every other event in the same cycle.
- overflow and seq_err are also cleared by clear.
- digest contents are left unchanged.
REQ-023 digest SHALL NOT be zeroed between collections; unwritten slots are overwritten by the next collection.

Reset
REQ-024 While resetn==0 (asynchronous), the block SHALL set:
- FSM state = IDLE; counter = 0
- digest = 0
- digest_valid = 0, busy = 0, overflow = 0, seq_err = 0
REQ-025 Reset asserted mid-collection or in HOLD SHALL discard all progress; no handshake completes on the release edge.

Configuration
REQ-026 With macro DIGEST_COMPARE_EN defined, the block SHALL add:
- input expected, 8*DIGEST_BYTES bits
- output match, 1 bit
- match is registered and is valid whenever digest_valid is high: it equals (digest==expected), computed at the cycle digest_valid rises.
- match is cleared by reset, by clear, and on handshake.
REQ-027 Without DIGEST_COMPARE_EN, the ports expected and match and all compare logic SHALL be absent.

Verification
REQ-028 Scenario: DIGEST_BYTES=32; send bytes 0x00..0x1F on consecutive cycles with hash_idx=0..31; digest_ready=1.
- digest_valid is high for exactly 1 cycle, 1 cycle after byte 31.
- digest = 0x1F1E..0100.
- overflow = 0, seq_err = 0.
REQ-029 Scenario: as REQ-028 with digest_ready=0 for 10 cycles, then 1.
- digest_valid and digest stay stable for 10 cycles.
- The handshake occurs on cycle 11; busy falls the next cycle.
REQ-030 Scenario: in HOLD, pulse hash_valid with hash_in=0xAA.
- overflow=1.
- digest is unchanged.
REQ-031 Scenario: send byte 5 with hash_idx=7.
- seq_err=1.
- The byte is stored in slot 5.
- Collection continues normally.
REQ-032 Scenario: assert clear after 12 bytes, then send 32 new bytes 0x80..0x9F.
- The new digest is 0x9F..80.
- There is no carry-over of the first 12 bytes.
REQ-033 Scenario: with DIGEST_COMPARE_EN defined, expected = the REQ-028 digest → match=1; flip one bit of expected → match=0; drop resetn mid-collection → all outputs return to their REQ-024 values immediately.
